// File: rtl/dm_unit_pkg.sv
// Shared definitions for the data-memory stage: access-size encodings, FSM
// states, default geometry/latency and request-legality helpers.
package dm_unit_pkg;

    localparam logic [2:0] MOP_W  = 3'b000;
    localparam logic [2:0] MOP_HS = 3'b001;
    localparam logic [2:0] MOP_HU = 3'b010;
    localparam logic [2:0] MOP_BS = 3'b011;
    localparam logic [2:0] MOP_BU = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_LATENCY    = 2;

    function automatic logic op_legal(input logic [2:0] op);
        return (op <= MOP_BU);
    endfunction

    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            MOP_W:          return (lane != 2'b00);
            MOP_HS, MOP_HU: return lane[0];
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Selects the addressed lane(s) of a memory word and sign/zero-extends them
// to 32 bits according to the access size; shared with write-back.
module dm_load_ext
    import dm_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  mem_op,
    output logic [31:0] value
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = lane[1] ? word[31:16] : word[15:0];
        byte_sel = word[8*lane +: 8];
        case (mem_op)
            MOP_HS:  value = {{16{half_sel[15]}}, half_sel};
            MOP_HU:  value = {16'h0000, half_sel};
            MOP_BS:  value = {{24{byte_sel[7]}}, byte_sel};
            MOP_BU:  value = {24'h000000, byte_sel};
            default: value = word;
        endcase
    end

endmodule

// File: rtl/dm_unit.sv
// Data-memory stage: multi-cycle word/half/byte loads and stores with
// alignment and range checking, busy/done handshake to the control unit.
module dm_unit
    import dm_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t state, state_nxt;
    logic [3:0] cnt_p0;

    logic                  we_p0;
    logic [2:0]            op_p0;
    logic [ADDR_WIDTH+1:0] addr_p0;
    logic [31:0]           wdata_p0;

    logic        bad, accept, reject, access;
    logic [3:0]  be;
    logic [31:0] wd, rd_word, ld_val;
    logic [31:0] mem [DEPTH];

    assign bad = !op_legal(mem_op) || misaligned(mem_op, addr[1:0])
                 || ((addr >> (ADDR_WIDTH + 2)) != 32'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req && !bad)    state_nxt = ST_WAIT;
            ST_WAIT: if (cnt_p0 == 4'd0) state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == ST_WAIT);
        accept = (state == ST_IDLE) && req && !bad;
        reject = (state == ST_IDLE) && req && bad;
        access = (state == ST_WAIT) && (cnt_p0 == 4'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p0 <= 4'd0;
            done   <= 1'b0;
            fault  <= 1'b0;
        end else begin
            done  <= access || reject;
            fault <= reject;
            if (accept)
                cnt_p0 <= 4'(LATENCY - 1);
            else if (busy && cnt_p0 != 4'd0)
                cnt_p0 <= cnt_p0 - 4'd1;
        end
    end

    // Request capture: inputs are frozen for the whole access so the caller may change them.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            we_p0    <= we;
            op_p0    <= mem_op;
            addr_p0  <= addr[ADDR_WIDTH+1:0];
            wdata_p0 <= wdata;
        end
    end

    always_comb begin
        be = 4'b0000;
        wd = wdata_p0;
        case (op_p0)
            MOP_W: be = 4'b1111;
            MOP_HS, MOP_HU: begin
                be = addr_p0[1] ? 4'b1100 : 4'b0011;
                wd = {2{wdata_p0[15:0]}};
            end
            MOP_BS, MOP_BU: begin
                be = 4'b0001 << addr_p0[1:0];
                wd = {4{wdata_p0[7:0]}};
            end
            default: be = 4'b0000;
        endcase
    end

    // Access edge: commit store lanes or capture the extended load value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else if (access && we_p0) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_p0[ADDR_WIDTH+1:2]][8*b +: 8] <= wd[8*b +: 8];
        end
    end

    assign rd_word = mem[addr_p0[ADDR_WIDTH+1:2]];

    dm_load_ext u_ext (
        .word   (rd_word),
        .lane   (addr_p0[1:0]),
        .mem_op (op_p0),
        .value  (ld_val)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                rdata <= 32'd0;
        else if (access && !we_p0) rdata <= ld_val;
    end

endmodule

// File: tb/tb_dm_unit.sv
// Scoreboard bench for dm_unit: directed accesses push expected completions,
// a monitor pops and checks them whenever done is presented.
module tb_dm_unit;
    import dm_unit_pkg::*;

    localparam int LAT  = 2;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [2:0]  mem_op = 3'b000;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic        busy, done, fault;

    logic        req3 = 1'b0, we3 = 1'b0;
    logic [2:0]  mem_op3 = 3'b000;
    logic [31:0] addr3 = 32'd0, wdata3 = 32'd0;
    logic [31:0] rdata3;
    logic        busy3, done3, fault3;

    dm_unit #(.ADDR_WIDTH(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .mem_op(mem_op),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .fault(fault)
    );

    dm_unit #(.ADDR_WIDTH(10), .LATENCY(LAT3)) u_dut3 (
        .clk(clk), .reset(reset), .req(req3), .we(we3), .mem_op(mem_op3),
        .addr(addr3), .wdata(wdata3), .rdata(rdata3), .busy(busy3),
        .done(done3), .fault(fault3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        f;
        logic [31:0] rd;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          nvec = 0;
    int          nfail = 0;
    logic [31:0] last_rd = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                nvec++;
                nfail++;
                $display("FAIL spurious_done: done at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_fault"}, 32'(fault), 32'(mon_e.f));
                chk({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                chk({mon_e.name, "_rdata"}, rdata, mon_e.rd);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic issue(input string nm, input logic w, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic ef, input logic [31:0] erd);
        exp_t e;
        req = 1'b1; we = w; mem_op = op; addr = a; wdata = d;
        e.f = ef; e.rd = erd; e.name = nm;
        e.cyc = cyc + 1 + (ef ? 0 : LAT);
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        chk({nm, "_busy"}, 32'(busy), 32'(!ef));
        if (!ef) begin
            for (int i = 1; i < LAT; i++) begin
                @(negedge clk);
                chk({nm, "_busy"}, 32'(busy), 32'd1);
            end
            @(negedge clk);
            chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic ld(input string nm, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] exp);
        last_rd = exp;
        issue(nm, 1'b0, op, a, 32'd0, 1'b0, exp);
    endtask

    task automatic st(input string nm, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] d);
        issue(nm, 1'b1, op, a, d, 1'b0, last_rd);
    endtask

    task automatic flt(input string nm, input logic w, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d);
        issue(nm, w, op, a, d, 1'b1, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        logic seen;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_fault", 32'(fault), 32'd0);

        st("sw10",  MOP_W, 32'h10, 32'h8000F0A5);
        ld("lw10",  MOP_W, 32'h10, 32'h8000F0A5);
        st("sw10z", MOP_W, 32'h10, 32'h00000000);
        st("sb13",  MOP_BS, 32'h13, 32'h000000AB);
        ld("lw10b", MOP_W,  32'h10, 32'hAB000000);
        ld("lb13",  MOP_BS, 32'h13, 32'hFFFFFFAB);
        ld("lbu13", MOP_BU, 32'h13, 32'h000000AB);
        ld("lb10",  MOP_BS, 32'h10, 32'h00000000);

        st("sh22",  MOP_HS, 32'h22, 32'h00008001);
        ld("lh22",  MOP_HS, 32'h22, 32'hFFFF8001);
        ld("lhu22", MOP_HU, 32'h22, 32'h00008001);
        ld("lw20",  MOP_W,  32'h20, 32'h80010000);
        ld("lh20",  MOP_HS, 32'h20, 32'h00000000);
        ld("lbu22", MOP_BU, 32'h22, 32'h00000001);
        ld("lb23",  MOP_BS, 32'h23, 32'hFFFFFF80);

        flt("f_lw02",   1'b0, MOP_W,  32'h02,       32'd0);
        flt("f_lh05",   1'b0, MOP_HS, 32'h05,       32'd0);
        flt("f_lw1000", 1'b0, MOP_W,  32'h00001000, 32'd0);
        flt("f_op111",  1'b0, 3'b111, 32'h10,       32'd0);
        flt("f_sw12",   1'b1, MOP_W,  32'h12,       32'hFFFFFFFF);
        flt("f_sh11",   1'b1, MOP_HU, 32'h11,       32'hFFFFFFFF);
        flt("f_sb1010", 1'b1, MOP_BU, 32'h00001010, 32'hFFFFFFFF);
        flt("f_op101",  1'b1, 3'b101, 32'h00,       32'hFFFFFFFF);
        ld("lw10_kept", MOP_W, 32'h10, 32'hAB000000);
        ld("lw00_kept", MOP_W, 32'h00, 32'h00000000);

        st("swffc", MOP_W,  32'hFFC, 32'h12345678);
        ld("lwffc", MOP_W,  32'hFFC, 32'h12345678);
        ld("lbfff", MOP_BS, 32'hFFF, 32'h00000012);

        // req held through WAIT with junk inputs, then a back-to-back request
        req = 1'b1; we = 1'b0; mem_op = MOP_W; addr = 32'h10; wdata = 32'd0;
        e.f = 1'b0; e.rd = 32'hAB000000; e.name = "hold1"; e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            we = 1'b1; mem_op = MOP_W; addr = 32'h14; wdata = 32'hFFFFFFFF;
        end
        @(negedge clk);
        we = 1'b0; mem_op = MOP_W; addr = 32'h20; wdata = 32'd0;
        e.rd = 32'h80010000; e.name = "b2b"; e.cyc = cyc + 1 + LAT;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        repeat (LAT) @(negedge clk);
        last_rd = 32'h80010000;
        ld("lw14_untouched", MOP_W, 32'h14, 32'h00000000);

        // reset during an in-flight store on the LATENCY=3 instance
        req3 = 1'b1; we3 = 1'b1; mem_op3 = MOP_W; addr3 = 32'h40; wdata3 = 32'hDEADBEEF;
        @(negedge clk);
        req3 = 1'b0;
        chk("l3_busy_before_rst", 32'(busy3), 32'd1);
        reset = 1'b1;
        #1;
        chk("l3_busy_in_rst",  32'(busy3), 32'd0);
        chk("l3_done_in_rst",  32'(done3), 32'd0);
        chk("rst_rdata_again", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        last_rd = 32'd0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done3) seen = 1'b1;
        end
        chk("l3_no_done", 32'(seen), 32'd0);

        req3 = 1'b1; we3 = 1'b0; mem_op3 = MOP_W; addr3 = 32'h40;
        @(negedge clk);
        req3 = 1'b0;
        n = 1;
        while (!done3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("l3_done_edge",  32'(n), 32'(LAT3 + 1));
        chk("l3_lw40",       rdata3, 32'h00000000);
        chk("l3_lw40_fault", 32'(fault3), 32'd0);

        ld("post_rst_lw10", MOP_W, 32'h10, 32'h00000000);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/dm_unit.md
Name: dm_unit

Overview:
- Data-memory stage directly downstream of the execute-stage ALU.
- Takes the ALU result as a byte address and the second register operand as store data.
- Performs word, halfword and byte loads and stores over a multi-cycle access, with alignment and range checking.
- Exposes busy/done so the control unit can stall the pipeline until the access completes.

Parameters:
- ADDR_WIDTH, 10, word-address bits (memory depth = 2^ADDR_WIDTH 32-bit words).
- LATENCY, 2, cycles from request-sampling edge to access edge; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  access request; sampled only when idle.
- we  input  1  1 = store, 0 = load.
- mem_op  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; others fault.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data, taken from the low bits for half/byte.
- rdata  output  32  load result after extension.
- busy  output  1  access in progress.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; request rejected.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; rdata=0, busy=0, done=0, fault=0, counter=0.
  - Whole memory array cleared to 0.
  - An in-flight access is aborted; no write occurs.
- States: IDLE, WAIT. busy = (state==WAIT). done and fault are registered and default to 0 every cycle.
- IDLE, req=1 at edge T:
  - Latch we, mem_op, addr, wdata.
  - Fault check: word with addr[1:0]!=0; half with addr[0]!=0; addr[31:ADDR_WIDTH+2]!=0; illegal mem_op.
  - On fault: done=1 and fault=1 in the cycle after T; state stays IDLE; no access; rdata unchanged.
  - Otherwise: state<=WAIT, counter<=LATENCY-1.
- WAIT, per edge:
  - counter!=0: decrement.
  - counter==0: perform the access, done<=1, state<=IDLE.
  - The access therefore occurs at edge T+LATENCY, and done is high for the cycle after it.
- req, we, mem_op, addr and wdata are ignored while busy=1.
- The done cycle is IDLE, so a new req can be sampled in that same cycle (back-to-back, no bubble).
- Byte lanes are little-endian: byte k of a word = bits 8k+7:8k.
- Store:
  - word writes all lanes.
  - half writes lanes {2*addr[1]+1, 2*addr[1]} with wdata[15:0].
  - byte writes lane addr[1:0] with wdata[7:0].
  - Signed/unsigned variants store identically.
  - rdata unchanged.
- Load:
  - rdata <= selected lane(s), sign- or zero-extended to 32 bits per mem_op.
  - Written at the access edge, held until the next completed load or reset.
- Word index = addr[ADDR_WIDTH+1:2].

Decomposition:
- Shared package holds:
  - mem_op encodings (MOP_W, MOP_HS, MOP_HU, MOP_BS, MOP_BU).
  - State encodings (ST_IDLE, ST_WAIT).
  - Default LATENCY and ADDR_WIDTH constants.
- One combinational sub-module, dm_load_ext:
  - Inputs: word, addr[1:0], mem_op.
  - Output: extended 32-bit load value.
  - Reused later by the write-back stage.
- Store byte-enable generation stays inline.

Test Plan:
- LATENCY=2: sw addr=0x10 wdata=0x8000F0A5 at edge T → done at T+2, busy high cycles T..T+1. Then lw 0x10 → rdata=0x8000F0A5, fault=0.
- sb addr=0x13 wdata=0x000000AB over a word of 0.
  - lw 0x10 → 0xAB000000.
  - lb 0x13 → 0xFFFFFFAB.
  - lbu 0x13 → 0x000000AB.
- sh addr=0x22 wdata=0x00008001.
  - lh 0x22 → 0xFFFF8001.
  - lhu 0x22 → 0x00008001.
  - lw 0x20 → 0x80010000.
- Faults (ADDR_WIDTH=10): each gives done=1, fault=1 one cycle after the request, busy never asserted, memory untouched.
  - lw 0x02.
  - lh 0x05.
  - lw 0x00001000.
  - mem_op=111.
- LATENCY=3: sw 0x40 0xDEADBEEF; assert reset one cycle after req → busy=0, done=0, no done pulse. lw 0x40 → 0x00000000.
- Hold req=1 with changing addr during WAIT → only the first request completes. A second req in the done cycle is accepted, with its done LATENCY+1 cycles after the first done.
